// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register write-back scoreboard.
package reg_scoreboard_pkg;
  localparam int NUM_GPR = 32;
  localparam int NUM_CSR = 4;
  localparam int INF_W   = 8;

  localparam logic [1:0] CSR_MCAUSE  = 2'd0;
  localparam logic [1:0] CSR_MEPC    = 2'd1;
  localparam logic [1:0] CSR_MSTATUS = 2'd2;
  localparam logic [1:0] CSR_MTVEC   = 2'd3;
endpackage

// File: rtl/sb_counter.sv
// Saturating-at-zero up/down pending counter; underflow flags a decrement of an empty count.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         nonzero,
  output logic         underflow
);
  logic [W-1:0] cnt_q, cnt_d;

  assign cnt       = cnt_q;
  assign nonzero   = |cnt_q;
  assign full      = &cnt_q;
  // clr wins over a same-cycle decrement, so a flushed retire never reports underflow
  assign underflow = dec & ~inc & ~nonzero & ~clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = '0;
    else if (inc & ~dec)             cnt_d = cnt_q + W'(1);
    else if (dec & ~inc & nonzero)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard: per-GPR/CSR pending counters gate the IDU issue handshake
// on RAW/WAW hazards and are released by WBU retire.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [4:0]           iss_rs1,
  input  logic [4:0]           iss_rs2,
  input  logic [1:0]           iss_rs_use,
  input  logic [1:0]           iss_csr_rs,
  input  logic                 iss_csr_rs_use,
  input  logic [4:0]           iss_rd,
  input  logic                 iss_reg_en,
  input  logic [1:0]           iss_csr_rd,
  input  logic                 iss_csreg_en,
  input  logic                 iss_ecall,
  input  logic                 ret_valid,
  input  logic [4:0]           ret_rd,
  input  logic                 ret_reg_en,
  input  logic [1:0]           ret_csr_rd,
  input  logic                 ret_csreg_en,
  input  logic                 ret_ecall,
  input  logic                 flush,
  output logic [NUM_GPR-1:0]   gpr_busy,
  output logic [NUM_CSR-1:0]   csr_busy,
  output logic [INF_W-1:0]     inflight,
  output logic                 err
);
  localparam logic [INF_W-1:0] MAX_INF = INF_W'(MAX_INFLIGHT);

  logic [NUM_GPR-1:1]             gpr_inc, gpr_dec, gpr_full, gpr_nz, gpr_uf;
  logic [NUM_GPR-1:1][CNT_W-1:0]  gpr_cnt_unused;
  logic [NUM_CSR-1:0]             csr_inc, csr_dec, csr_full, csr_nz, csr_uf;
  logic [NUM_CSR-1:0][CNT_W-1:0]  csr_cnt_unused;
  logic [NUM_GPR-1:0]             gpr_full_all;
  logic                           inf_full, inf_nz_unused, inf_uf;
  logic                           iss_fire, src_hazard, dst_full;
  logic                           err_q, err_d;

  assign gpr_busy     = {gpr_nz, 1'b0};
  assign gpr_full_all = {gpr_full, 1'b0};
  assign csr_busy     = csr_nz;
  assign err          = err_q;

  // Ready looks only at registered counts: a same-cycle retire does not unblock.
  always_comb begin
    src_hazard = (iss_rs_use[0] & gpr_busy[iss_rs1]) |
                 (iss_rs_use[1] & gpr_busy[iss_rs2]) |
                 (iss_csr_rs_use & csr_busy[iss_csr_rs]);
    dst_full   = (iss_reg_en & (iss_rd != 5'd0) & gpr_full_all[iss_rd]) |
                 (iss_csreg_en & csr_full[iss_csr_rd]) |
                 (iss_ecall & csr_full[CSR_MCAUSE]);
    iss_ready  = ~src_hazard & ~dst_full & (inflight < MAX_INF) & ~inf_full & ~flush;
    iss_fire   = iss_valid & iss_ready;
  end

  // ecall and an explicit mcause write merge into a single count
  always_comb begin
    for (int i = 1; i < NUM_GPR; i++) begin
      gpr_inc[i] = iss_fire & iss_reg_en & (iss_rd == 5'(i));
      gpr_dec[i] = ret_valid & ret_reg_en & (ret_rd == 5'(i));
    end
    for (int i = 0; i < NUM_CSR; i++) begin
      csr_inc[i] = iss_fire & ((iss_csreg_en & (iss_csr_rd == 2'(i))) |
                               (iss_ecall & (2'(i) == CSR_MCAUSE)));
      csr_dec[i] = ret_valid & ((ret_csreg_en & (ret_csr_rd == 2'(i))) |
                                (ret_ecall & (2'(i) == CSR_MCAUSE)));
    end
  end

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_gpr
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .inc(gpr_inc[g]), .dec(gpr_dec[g]), .clr(flush),
      .cnt(gpr_cnt_unused[g]), .full(gpr_full[g]), .nonzero(gpr_nz[g]), .underflow(gpr_uf[g])
    );
  end

  for (genvar g = 0; g < NUM_CSR; g++) begin : g_csr
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .inc(csr_inc[g]), .dec(csr_dec[g]), .clr(flush),
      .cnt(csr_cnt_unused[g]), .full(csr_full[g]), .nonzero(csr_nz[g]), .underflow(csr_uf[g])
    );
  end

  sb_counter #(.W(INF_W)) u_inflight (
    .clk(clk), .rst(rst), .inc(iss_fire), .dec(ret_valid), .clr(flush),
    .cnt(inflight), .full(inf_full), .nonzero(inf_nz_unused), .underflow(inf_uf)
  );

  always_comb err_d = err_q | (|gpr_uf) | (|csr_uf) | inf_uf;

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard plus a few multi-cycle sequences.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic iss_valid, iss_ready, iss_csr_rs_use, iss_reg_en, iss_csreg_en, iss_ecall;
  logic [4:0] iss_rs1, iss_rs2, iss_rd, ret_rd;
  logic [1:0] iss_rs_use, iss_csr_rs, iss_csr_rd, ret_csr_rd;
  logic ret_valid, ret_reg_en, ret_csreg_en, ret_ecall, flush;
  logic [31:0] gpr_busy;
  logic [3:0]  csr_busy;
  logic [7:0]  inflight;
  logic        err;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs_use(iss_rs_use),
    .iss_csr_rs(iss_csr_rs), .iss_csr_rs_use(iss_csr_rs_use),
    .iss_rd(iss_rd), .iss_reg_en(iss_reg_en),
    .iss_csr_rd(iss_csr_rd), .iss_csreg_en(iss_csreg_en), .iss_ecall(iss_ecall),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_reg_en(ret_reg_en),
    .ret_csr_rd(ret_csr_rd), .ret_csreg_en(ret_csreg_en), .ret_ecall(ret_ecall),
    .flush(flush),
    .gpr_busy(gpr_busy), .csr_busy(csr_busy), .inflight(inflight), .err(err)
  );

  typedef struct packed {
    logic        do_rst;
    logic        fl;
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  ruse;
    logic [1:0]  crs;
    logic        cuse;
    logic [4:0]  rd;
    logic        ren;
    logic [1:0]  crd;
    logic        cen;
    logic        ecall;
    logic        rv;
    logic [4:0]  rrd;
    logic        rren;
    logic [1:0]  rcrd;
    logic        rcen;
    logic        recall;
    logic        x_rdy;
    logic [31:0] x_gpr;
    logic [3:0]  x_csr;
    logic [7:0]  x_inf;
    logic        x_err;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Drive at negedge, check ready before the edge, check state after it.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = ~v.do_rst; flush = v.fl;
    iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rs_use = v.ruse;
    iss_csr_rs = v.crs; iss_csr_rs_use = v.cuse; iss_rd = v.rd; iss_reg_en = v.ren;
    iss_csr_rd = v.crd; iss_csreg_en = v.cen; iss_ecall = v.ecall;
    ret_valid = v.rv; ret_rd = v.rrd; ret_reg_en = v.rren;
    ret_csr_rd = v.rcrd; ret_csreg_en = v.rcen; ret_ecall = v.recall;
    #1;
    chk("iss_ready", idx, 32'(iss_ready), 32'(v.x_rdy));
    @(posedge clk); #1;
    chk("gpr_busy", idx, gpr_busy, v.x_gpr);
    chk("csr_busy", idx, 32'(csr_busy), 32'(v.x_csr));
    chk("inflight", idx, 32'(inflight), 32'(v.x_inf));
    chk("err", idx, 32'(err), 32'(v.x_err));
    vectors++;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rs_use = '0;
    iss_csr_rs = '0; iss_csr_rs_use = 1'b0; iss_rd = '0; iss_reg_en = 1'b0; iss_csr_rd = '0;
    iss_csreg_en = 1'b0; iss_ecall = 1'b0; ret_valid = 1'b0; ret_rd = '0; ret_reg_en = 1'b0;
    ret_csr_rd = '0; ret_csreg_en = 1'b0; ret_ecall = 1'b0;
    repeat (2) @(posedge clk);

    tbl.push_back('{do_rst:1'b1, x_rdy:1'b1, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd5, ren:1'b1, x_rdy:1'b1, x_gpr:32'h20, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, rs1:5'd5, ruse:2'b01, rd:5'd6, ren:1'b1, x_gpr:32'h20, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, rs1:5'd5, ruse:2'b01, rd:5'd6, ren:1'b1, rv:1'b1, rrd:5'd5, rren:1'b1, default:'0});
    tbl.push_back('{iv:1'b1, rs1:5'd5, ruse:2'b01, rd:5'd6, ren:1'b1, x_rdy:1'b1, x_gpr:32'h40, x_inf:8'd1, default:'0});
    tbl.push_back('{rv:1'b1, rrd:5'd6, rren:1'b1, x_rdy:1'b1, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd0, ren:1'b1, x_rdy:1'b1, x_inf:8'd1, default:'0});
    tbl.push_back('{rv:1'b1, rrd:5'd0, rren:1'b1, x_rdy:1'b1, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd7, ren:1'b1, x_rdy:1'b1, x_gpr:32'h80, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd7, ren:1'b1, rv:1'b1, rrd:5'd7, rren:1'b1, x_rdy:1'b1, x_gpr:32'h80, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, rs2:5'd7, ruse:2'b10, rd:5'd8, ren:1'b1, rv:1'b1, rrd:5'd7, rren:1'b1, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd3, ren:1'b1, x_rdy:1'b1, x_gpr:32'h8, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd3, ren:1'b1, x_rdy:1'b1, x_gpr:32'h8, x_inf:8'd2, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd3, ren:1'b1, x_rdy:1'b1, x_gpr:32'h8, x_inf:8'd3, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd3, ren:1'b1, x_gpr:32'h8, x_inf:8'd3, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd10, ren:1'b1, x_rdy:1'b1, x_gpr:32'h408, x_inf:8'd4, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd11, ren:1'b1, x_gpr:32'h408, x_inf:8'd4, default:'0});
    tbl.push_back('{rv:1'b1, rrd:5'd3, rren:1'b1, x_gpr:32'h408, x_inf:8'd3, default:'0});
    tbl.push_back('{rv:1'b1, rrd:5'd3, rren:1'b1, x_rdy:1'b1, x_gpr:32'h408, x_inf:8'd2, default:'0});
    tbl.push_back('{rv:1'b1, rrd:5'd3, rren:1'b1, x_rdy:1'b1, x_gpr:32'h400, x_inf:8'd1, default:'0});
    tbl.push_back('{rv:1'b1, rrd:5'd10, rren:1'b1, x_rdy:1'b1, default:'0});
    tbl.push_back('{iv:1'b1, ecall:1'b1, cen:1'b1, crd:2'd0, x_rdy:1'b1, x_csr:4'b0001, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, cuse:1'b1, crs:2'd0, x_csr:4'b0001, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, cuse:1'b1, crs:2'd1, cen:1'b1, crd:2'd2, x_rdy:1'b1, x_csr:4'b0101, x_inf:8'd2, default:'0});
    tbl.push_back('{rv:1'b1, recall:1'b1, rcen:1'b1, rcrd:2'd0, x_rdy:1'b1, x_csr:4'b0100, x_inf:8'd1, default:'0});
    tbl.push_back('{iv:1'b1, cuse:1'b1, crs:2'd0, x_rdy:1'b1, x_csr:4'b0100, x_inf:8'd2, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd12, ren:1'b1, x_rdy:1'b1, x_gpr:32'h1000, x_csr:4'b0100, x_inf:8'd3, default:'0});
    tbl.push_back('{fl:1'b1, rv:1'b1, rrd:5'd12, rren:1'b1, iv:1'b1, rd:5'd13, ren:1'b1, default:'0});
    tbl.push_back('{rv:1'b1, rrd:5'd12, rren:1'b1, x_rdy:1'b1, x_err:1'b1, default:'0});
    tbl.push_back('{x_rdy:1'b1, x_err:1'b1, default:'0});
    tbl.push_back('{iv:1'b1, rd:5'd1, ren:1'b1, x_rdy:1'b1, x_gpr:32'h2, x_inf:8'd1, x_err:1'b1, default:'0});
    tbl.push_back('{do_rst:1'b1, iv:1'b1, rd:5'd2, ren:1'b1, rv:1'b1, rrd:5'd1, rren:1'b1, x_rdy:1'b1, default:'0});

    foreach (tbl[i]) apply(tbl[i], i);

    // CSR/inflight underflow from an idle state sets the sticky error; reset clears it.
    apply('{rv:1'b1, recall:1'b1, x_rdy:1'b1, x_err:1'b1, default:'0}, 100);
    apply('{x_rdy:1'b1, x_err:1'b1, default:'0}, 101);
    apply('{do_rst:1'b1, x_rdy:1'b1, default:'0}, 102);

    // RAW on rd=20 stays blocked across several cycles, then releases after retire.
    apply('{iv:1'b1, rd:5'd20, ren:1'b1, x_rdy:1'b1, x_gpr:32'h0010_0000, x_inf:8'd1, default:'0}, 110);
    for (int c = 0; c < 3; c++)
      apply('{iv:1'b1, rs1:5'd20, ruse:2'b01, x_gpr:32'h0010_0000, x_inf:8'd1, default:'0}, 111 + c);
    apply('{iv:1'b1, rs1:5'd20, ruse:2'b01, rv:1'b1, rrd:5'd20, rren:1'b1, default:'0}, 114);
    begin
      int waited = 0;
      @(negedge clk);
      iss_valid = 1'b1; iss_rs1 = 5'd20; iss_rs_use = 2'b01;
      ret_valid = 1'b0; ret_reg_en = 1'b0;
      #1;
      while (!iss_ready && waited < 5) begin
        @(negedge clk); #1;
        waited++;
      end
      chk("release_wait", 115, 32'(waited), 32'd0);
      @(posedge clk); #1;
      chk("release_inflight", 115, 32'(inflight), 32'd1);
      vectors++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
